exe_hazard_ctrl: RTL and testbench

Pipeline controller for the execute stage of the ARM 5-stage core.
- Produces forwarding selects for the EXE operands (Val_Rn, Val_Rm).
- Detects load-use / RAW hazards and stalls IF/ID.
- Sequences branch flushes and owns the NZCV status register, which feeds the EXE ALU carry-in and ID condition check.
- Keeps saturating stall/flush event counters for lab measurements.

---
 rtl/arm_defs_pkg.sv | 43 ++++
 rtl/forward_unit.sv | 21 ++
 rtl/exe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_defs_pkg.sv
// Shared encodings for the ARM 5-stage execute-stage controller: forwarding
// selects, NZCV bit positions and the operand-forwarding priority helper.
package arm_defs;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } ctrl_state_e;

   // MEM result is younger than WB, so it wins when both write the source.
   function automatic logic [1:0] fwd_pick(
      input logic       en,
      input logic       mem_wb_en,
      input logic [3:0] mem_dest,
      input logic       wb_wb_en,
      input logic [3:0] wb_dest,
      input logic [3:0] src
   );
      logic [1:0] sel;
      if (!en) begin
         sel = FWD_REG;
      end else if (mem_wb_en && (mem_dest == src)) begin
         sel = FWD_MEM;
      end else if (wb_wb_en && (wb_dest == src)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_REG;
      end
      return sel;
   endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forwarding selects for the EXE stage Val_Rn / Val_Rm.
module forward_unit
   import arm_defs::*;
(
   input  logic       forward_en,
   input  logic [3:0] exe_src1,
   input  logic [3:0] exe_src2,
   input  logic [3:0] mem_dest,
   input  logic       mem_wb_en,
   input  logic [3:0] wb_dest,
   input  logic       wb_wb_en,
   output logic [1:0] fwd_sel1,
   output logic [1:0] fwd_sel2
);

   always_comb begin
      fwd_sel1 = fwd_pick(forward_en, mem_wb_en, mem_dest, wb_wb_en, wb_dest, exe_src1);
      fwd_sel2 = fwd_pick(forward_en, mem_wb_en, mem_dest, wb_wb_en, wb_dest, exe_src2);
   end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage pipeline controller: forwarding, load-use/RAW stall, branch
// flush sequencing, NZCV status register and saturating event counters.
module exe_hazard_ctrl
   import arm_defs::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_en,
   input  logic             id_valid,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_two_src,
   input  logic             exe_valid,
   input  logic [3:0]       exe_src1,
   input  logic [3:0]       exe_src2,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic             exe_s,
   input  logic             exe_b,
   input  logic [3:0]       alu_status,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic [3:0]       wb_dest,
   input  logic             wb_wb_en,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2,
   output logic             hazard_stall,
   output logic             flush,
   output logic [3:0]       status_out,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   ctrl_state_e      state_q;
   logic [1:0]       rem_q;
   logic [3:0]       status_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [1:0] fwd_sel1_s, fwd_sel2_s;
   logic       hazard_s;
   logic       flush_entry_s;
   logic       match_exe_s, match_mem_s;

   forward_unit u_forward_unit (
      .forward_en (forward_en),
      .exe_src1   (exe_src1),
      .exe_src2   (exe_src2),
      .mem_dest   (mem_dest),
      .mem_wb_en  (mem_wb_en),
      .wb_dest    (wb_dest),
      .wb_wb_en   (wb_wb_en),
      .fwd_sel1   (fwd_sel1_s),
      .fwd_sel2   (fwd_sel2_s)
   );

   // Only sources that ID really reads can create a dependency.
   always_comb begin
      match_exe_s = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
      match_mem_s = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));
      if (!id_valid) begin
         hazard_s = 1'b0;
      end else if (forward_en) begin
         hazard_s = exe_valid && exe_mem_r_en && match_exe_s;
      end else begin
         hazard_s = (exe_valid && exe_wb_en && match_exe_s) || (mem_wb_en && match_mem_s);
      end
   end

   assign flush_entry_s = (state_q == ST_RUN) && exe_b && exe_valid;

   // Combinational outputs are forced low while reset is held.
   always_comb begin
      if (!rst) begin
         fwd_sel1     = FWD_REG;
         fwd_sel2     = FWD_REG;
         hazard_stall = 1'b0;
         flush        = 1'b0;
      end else begin
         fwd_sel1     = fwd_sel1_s;
         fwd_sel2     = fwd_sel2_s;
         hazard_stall = hazard_s && (state_q == ST_RUN) && !exe_b;
         flush        = (state_q == ST_FLUSH) || flush_entry_s;
      end
   end

   // Flush sequencer; branches seen while flushing belong to squashed slots.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         rem_q   <= 2'd0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (flush_entry_s && (FLUSH_CYCLES > 1)) begin
                  state_q <= ST_FLUSH;
                  rem_q   <= FLUSH_LOAD;
               end else begin
                  state_q <= ST_RUN;
                  rem_q   <= 2'd0;
               end
            end
            ST_FLUSH: begin
               if (rem_q <= 2'd1) begin
                  state_q <= ST_RUN;
                  rem_q   <= 2'd0;
               end else begin
                  state_q <= ST_FLUSH;
                  rem_q   <= rem_q - 2'd1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               rem_q   <= 2'd0;
            end
         endcase
      end
   end

   // Falling-edge update lets ID's condition check see the new flags this cycle.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         status_q <= 4'h0;
      end else if (exe_valid && exe_s && (state_q == ST_RUN)) begin
         status_q <= alu_status;
      end else begin
         status_q <= status_q;
      end
   end

   // Saturating increments: the counters stick at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (hazard_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush_entry_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Event counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign status_out = status_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed, table-driven bench for exe_hazard_ctrl with FLUSH_CYCLES=2.
module tb_exe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        forward_en, id_valid, id_two_src;
   logic [3:0]  id_src1, id_src2;
   logic        exe_valid, exe_wb_en, exe_mem_r_en, exe_s, exe_b;
   logic [3:0]  exe_src1, exe_src2, exe_dest, alu_status;
   logic [3:0]  mem_dest, wb_dest;
   logic        mem_wb_en, wb_wb_en;
   logic [1:0]  fwd_sel1, fwd_sel2;
   logic        hazard_stall, flush;
   logic [3:0]  status_out;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int failures = 0;

   exe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
      .exe_valid(exe_valid), .exe_src1(exe_src1), .exe_src2(exe_src2),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .exe_s(exe_s), .exe_b(exe_b), .alu_status(alu_status),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
      .wb_wb_en(wb_wb_en), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .hazard_stall(hazard_stall), .flush(flush), .status_out(status_out),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic fe; logic idv; logic [3:0] is1; logic [3:0] is2; logic two;
      logic exv; logic [3:0] es1; logic [3:0] es2; logic [3:0] ed; logic ewb; logic eld;
      logic [3:0] md; logic mwb; logic [3:0] wd; logic wwb;
      logic [1:0] s1; logic [1:0] s2; logic st;
   } vec_t;

   vec_t tv[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      forward_en = 1'b0; id_valid = 1'b0; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
      exe_valid = 1'b0; exe_src1 = 4'd0; exe_src2 = 4'd0; exe_dest = 4'd0;
      exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_s = 1'b0; exe_b = 1'b0; alu_status = 4'd0;
      mem_dest = 4'd0; mem_wb_en = 1'b0; wb_dest = 4'd0; wb_wb_en = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      forward_en = v.fe; id_valid = v.idv; id_src1 = v.is1; id_src2 = v.is2; id_two_src = v.two;
      exe_valid = v.exv; exe_src1 = v.es1; exe_src2 = v.es2; exe_dest = v.ed;
      exe_wb_en = v.ewb; exe_mem_r_en = v.eld;
      mem_dest = v.md; mem_wb_en = v.mwb; wb_dest = v.wd; wb_wb_en = v.wwb;
      exe_s = 1'b0; exe_b = 1'b0; alu_status = 4'd0;
   endtask

   initial begin
      int exp_stall;
      //        fe   idv  is1   is2   two  exv  es1   es2   ed    ewb  eld  md    mwb  wd    wwb  s1    s2    st
      tv[0]  = '{1'b1,1'b0,4'd0, 4'd0, 1'b0,1'b0,4'd3, 4'd7, 4'd0, 1'b0,1'b0,4'd3, 1'b1,4'd0, 1'b0,2'd1, 2'd0, 1'b0};
      tv[1]  = '{1'b1,1'b0,4'd0, 4'd0, 1'b0,1'b0,4'd3, 4'd3, 4'd0, 1'b0,1'b0,4'd3, 1'b1,4'd3, 1'b1,2'd1, 2'd1, 1'b0};
      tv[2]  = '{1'b1,1'b0,4'd0, 4'd0, 1'b0,1'b0,4'd3, 4'd9, 4'd0, 1'b0,1'b0,4'd3, 1'b0,4'd3, 1'b1,2'd2, 2'd0, 1'b0};
      tv[3]  = '{1'b0,1'b0,4'd0, 4'd0, 1'b0,1'b0,4'd3, 4'd3, 4'd0, 1'b0,1'b0,4'd3, 1'b1,4'd3, 1'b1,2'd0, 2'd0, 1'b0};
      tv[4]  = '{1'b1,1'b0,4'd0, 4'd0, 1'b0,1'b0,4'd4, 4'd6, 4'd0, 1'b0,1'b0,4'd6, 1'b1,4'd4, 1'b1,2'd2, 2'd1, 1'b0};
      tv[5]  = '{1'b1,1'b0,4'd0, 4'd0, 1'b0,1'b0,4'd5, 4'd5, 4'd0, 1'b0,1'b0,4'd5, 1'b0,4'd5, 1'b0,2'd0, 2'd0, 1'b0};
      tv[6]  = '{1'b1,1'b1,4'd1, 4'd5, 1'b1,1'b1,4'd0, 4'd0, 4'd5, 1'b1,1'b1,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b1};
      tv[7]  = '{1'b1,1'b1,4'd1, 4'd5, 1'b0,1'b1,4'd0, 4'd0, 4'd5, 1'b1,1'b1,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b0};
      tv[8]  = '{1'b1,1'b1,4'd1, 4'd5, 1'b1,1'b1,4'd0, 4'd0, 4'd5, 1'b1,1'b0,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b0};
      tv[9]  = '{1'b1,1'b1,4'd5, 4'd0, 1'b0,1'b1,4'd0, 4'd0, 4'd5, 1'b1,1'b1,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b1};
      tv[10] = '{1'b1,1'b0,4'd5, 4'd0, 1'b0,1'b1,4'd0, 4'd0, 4'd5, 1'b1,1'b1,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b0};
      tv[11] = '{1'b1,1'b1,4'd5, 4'd0, 1'b0,1'b0,4'd0, 4'd0, 4'd5, 1'b1,1'b1,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b0};
      tv[12] = '{1'b0,1'b1,4'd2, 4'd0, 1'b0,1'b1,4'd0, 4'd0, 4'd2, 1'b1,1'b0,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b1};
      tv[13] = '{1'b0,1'b1,4'd1, 4'd8, 1'b1,1'b0,4'd0, 4'd0, 4'd0, 1'b0,1'b0,4'd8, 1'b1,4'd0, 1'b0,2'd0, 2'd0, 1'b1};
      tv[14] = '{1'b0,1'b1,4'd1, 4'd8, 1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,1'b0,4'd8, 1'b1,4'd0, 1'b0,2'd0, 2'd0, 1'b0};
      tv[15] = '{1'b0,1'b1,4'd2, 4'd0, 1'b0,1'b1,4'd0, 4'd0, 4'd2, 1'b0,1'b0,4'd0, 1'b0,4'd0, 1'b0,2'd0, 2'd0, 1'b0};
      tv[16] = '{1'b0,1'b1,4'd9, 4'd0, 1'b0,1'b0,4'd0, 4'd0, 4'd0, 1'b0,1'b0,4'd0, 1'b0,4'd9, 1'b1,2'd0, 2'd0, 1'b0};

      // Reset state
      clr();
      rst = 1'b0;
      #12;
      chk("rst_sel1", 32'(fwd_sel1), 32'd0);
      chk("rst_stall", 32'(hazard_stall), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_status", 32'(status_out), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      cyc();
      rst = 1'b1;

      // Table of combinational forwarding / hazard vectors, one cycle each
      exp_stall = 0;
      for (int i = 0; i < 17; i++) begin
         cyc();
         apply(tv[i]);
         #1;
         chk($sformatf("vec%0d_sel1", i), 32'(fwd_sel1), 32'(tv[i].s1));
         chk($sformatf("vec%0d_sel2", i), 32'(fwd_sel2), 32'(tv[i].s2));
         chk($sformatf("vec%0d_stall", i), 32'(hazard_stall), 32'(tv[i].st));
         if (tv[i].st) exp_stall++;
      end
      cyc();
      clr();
      chk("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

      // Load-use stalls exactly one cycle, then a bubble reaches EXE
      forward_en = 1'b1; id_valid = 1'b1; id_src1 = 4'd1; id_src2 = 4'd5; id_two_src = 1'b1;
      exe_valid = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
      #1;
      chk("ldu_stall", 32'(hazard_stall), 32'd1);
      cyc();
      exe_valid = 1'b0; exe_mem_r_en = 1'b0; exe_wb_en = 1'b0;
      #1;
      chk("ldu_bubble_stall", 32'(hazard_stall), 32'd0);
      chk("ldu_cnt", 32'(stall_cnt), 32'(exp_stall + 1));
      cyc();
      chk("ldu_cnt_hold", 32'(stall_cnt), 32'(exp_stall + 1));
      clr();

      // Status register loads on the falling edge
      exe_valid = 1'b1; exe_s = 1'b1; alu_status = 4'b0110;
      @(negedge clk); #1;
      chk("nzcv_load", 32'(status_out), 32'h6);
      cyc();
      exe_s = 1'b0; alu_status = 4'b1111;
      @(negedge clk); #1;
      chk("nzcv_no_s", 32'(status_out), 32'h6);
      cyc();
      exe_valid = 1'b0; exe_s = 1'b1;
      @(negedge clk); #1;
      chk("nzcv_invalid", 32'(status_out), 32'h6);
      cyc();
      clr();

      // Taken branch with a simultaneous load-use hazard and S=1
      forward_en = 1'b1; id_valid = 1'b1; id_src1 = 4'd5;
      exe_valid = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
      exe_b = 1'b1; exe_s = 1'b1; alu_status = 4'b0011;
      #1;
      chk("br_flush0", 32'(flush), 32'd1);
      chk("br_stall0", 32'(hazard_stall), 32'd0);
      @(negedge clk); #1;
      chk("br_nzcv", 32'(status_out), 32'h3);
      cyc();
      alu_status = 4'b1100;
      #1;
      chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("br_flush1", 32'(flush), 32'd1);
      chk("br_stall1", 32'(hazard_stall), 32'd0);
      @(negedge clk); #1;
      chk("br_nzcv_flushed", 32'(status_out), 32'h3);
      cyc();
      clr();
      #1;
      chk("br_flush_end", 32'(flush), 32'd0);
      chk("br_flush_cnt_hold", 32'(flush_cnt), 32'd1);
      chk("br_stall_cnt", 32'(stall_cnt), 32'(exp_stall + 1));

      // Reset asserted mid-flush aborts at once
      exe_valid = 1'b1; exe_b = 1'b1;
      cyc();
      clr();
      forward_en = 1'b1; mem_wb_en = 1'b1; mem_dest = 4'd3; exe_src1 = 4'd3;
      #1;
      chk("rf_flush_pre", 32'(flush), 32'd1);
      chk("rf_sel1_pre", 32'(fwd_sel1), 32'd1);
      rst = 1'b0;
      #1;
      chk("rf_flush", 32'(flush), 32'd0);
      chk("rf_sel1", 32'(fwd_sel1), 32'd0);
      chk("rf_status", 32'(status_out), 32'd0);
      chk("rf_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rf_flush_cnt", 32'(flush_cnt), 32'd0);
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      chk("rf_run_flush", 32'(flush), 32'd0);
      chk("rf_run_sel1", 32'(fwd_sel1), 32'd1);
      cyc();
      clr();

      // Stall counter saturation with a held RAW stall
      id_valid = 1'b1; id_src1 = 4'd2; exe_valid = 1'b1; exe_dest = 4'd2; exe_wb_en = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      chk("sat_stall", 32'(hazard_stall), 32'd1);
      chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
      cyc();
      chk("sat_cnt_hold", 32'(stall_cnt), 32'hFFFF);
      clr();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
